// File: rtl/regfile_psr.sv
// rtl/regfile_psr.sv - 16x16 general register file with 5-bit processor status register
module regfile_psr #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] raddr_src,
  input  logic [ADDR_W-1:0] raddr_dest,
  output logic [DATA_W-1:0] rdata_src,
  output logic [DATA_W-1:0] rdata_dest,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [4:0]        flags_in,
  input  logic [4:0]        flag_we,
  output logic [4:0]        psr_out,
  input  logic              psr_load,
  input  logic [4:0]        psr_wdata
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [4:0]        psr;
  logic              wr_ok;

  // Addresses past the last implemented register are treated as holes.
  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return (int'(addr) < NUM_REGS);
  endfunction

  // One read port: holes read 0, a same-cycle write is forwarded when enabled.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    val = '0;
    if (in_range(addr)) begin
      if (BYPASS && we && (waddr == addr)) begin
        val = wdata;
      end else begin
        val = regs[addr];
      end
    end
    return val;
  endfunction

  // A write only lands when enabled and aimed at an implemented register.
  always_comb begin
    wr_ok = we && in_range(waddr);
  end

  // Register array update; reset wipes every entry and drops any pending write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[waddr] <= wdata;
    end
  end

  // PSR: bulk load wins over the per-bit flag mask; unmasked bits hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      psr <= 5'b00000;
    end else if (psr_load) begin
      psr <= psr_wdata;
    end else begin
      psr <= (flags_in & flag_we) | (psr & ~flag_we);
    end
  end

  // Combinational operand reads for the ALU.
  always_comb begin
    rdata_src  = read_port(raddr_src);
    rdata_dest = read_port(raddr_dest);
    psr_out    = psr;
  end

endmodule

// File: tb/tb_regfile_psr.sv
// tb/tb_regfile_psr.sv - self-checking bench for regfile_psr (bypass, no-bypass, 12-entry variants)
module tb_regfile_psr;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  raddr_src, raddr_dest, waddr;
  logic [15:0] wdata;
  logic        we;
  logic [4:0]  flags_in, flag_we, psr_wdata;
  logic        psr_load;

  logic [15:0] rs [3];
  logic [15:0] rd [3];
  logic [4:0]  ps [3];

  int checks = 0;
  int passes = 0;
  bit chk_en = 1'b0;

  // Reference state: index 0 = bypass/16 regs, 1 = no bypass, 2 = 12 regs.
  logic [15:0] model_regs [3][16];
  logic [4:0]  model_psr  [3];

  always #5 clk = ~clk;

  regfile_psr u_byp (
    .clk(clk), .reset(reset), .raddr_src(raddr_src), .raddr_dest(raddr_dest),
    .rdata_src(rs[0]), .rdata_dest(rd[0]), .we(we), .waddr(waddr), .wdata(wdata),
    .flags_in(flags_in), .flag_we(flag_we), .psr_out(ps[0]),
    .psr_load(psr_load), .psr_wdata(psr_wdata)
  );

  regfile_psr #(.BYPASS(1'b0)) u_nobyp (
    .clk(clk), .reset(reset), .raddr_src(raddr_src), .raddr_dest(raddr_dest),
    .rdata_src(rs[1]), .rdata_dest(rd[1]), .we(we), .waddr(waddr), .wdata(wdata),
    .flags_in(flags_in), .flag_we(flag_we), .psr_out(ps[1]),
    .psr_load(psr_load), .psr_wdata(psr_wdata)
  );

  regfile_psr #(.NUM_REGS(12)) u_small (
    .clk(clk), .reset(reset), .raddr_src(raddr_src), .raddr_dest(raddr_dest),
    .rdata_src(rs[2]), .rdata_dest(rd[2]), .we(we), .waddr(waddr), .wdata(wdata),
    .flags_in(flags_in), .flag_we(flag_we), .psr_out(ps[2]),
    .psr_load(psr_load), .psr_wdata(psr_wdata)
  );

  function automatic int nregs_of(input int k);
    return (k == 2) ? 12 : 16;
  endfunction

  function automatic bit bypass_of(input int k);
    return (k != 1);
  endfunction

  function automatic logic [15:0] exp_read(input int k, input logic [3:0] a);
    if (int'(a) >= nregs_of(k)) return 16'h0000;
    if (bypass_of(k) && we && (waddr == a)) return wdata;
    return model_regs[k][a];
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Model advances on the same edge as the DUTs, from the architectural rules.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        for (int i = 0; i < 16; i++) model_regs[k][i] <= 16'h0000;
        model_psr[k] <= 5'b00000;
      end else begin
        if (we && int'(waddr) < nregs_of(k)) model_regs[k][waddr] <= wdata;
        for (int b = 0; b < 5; b++) begin
          if (psr_load)        model_psr[k][b] <= psr_wdata[b];
          else if (flag_we[b]) model_psr[k][b] <= flags_in[b];
        end
      end
    end
  end

  // Every cycle, away from the active edge, compare all three DUTs to the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("cyc_src%0d[%0d]", k, raddr_src), rs[k], exp_read(k, raddr_src));
        check($sformatf("cyc_dest%0d[%0d]", k, raddr_dest), rd[k], exp_read(k, raddr_dest));
        check($sformatf("cyc_psr%0d", k), {11'd0, ps[k]}, {11'd0, model_psr[k]});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Flag-mask vectors: {start psr via load, flags_in, flag_we, expected psr}.
  logic [4:0] fv_start [4] = '{5'b00000, 5'b11111, 5'b10101, 5'b01100};
  logic [4:0] fv_flags [4] = '{5'b11111, 5'b00000, 5'b01010, 5'b10011};
  logic [4:0] fv_mask  [4] = '{5'b01010, 5'b10001, 5'b11111, 5'b00110};
  logic [4:0] fv_exp   [4] = '{5'b01010, 5'b01110, 5'b01010, 5'b01010};

  initial begin
    reset = 1'b1; we = 1'b1; waddr = 4'd3; wdata = 16'hFFFF;
    raddr_src = 4'd3; raddr_dest = 4'd0;
    flags_in = 5'b11111; flag_we = 5'b11111; psr_load = 1'b1; psr_wdata = 5'b11111;
    tick;
    chk_en = 1'b1;
    tick;
    reset = 1'b0; we = 1'b0; wdata = 16'hDEAD; waddr = 4'd3;
    psr_load = 1'b0; flag_we = 5'b00000;
    #1;
    check("reset_r3", rs[0], 16'h0000);
    check("reset_psr", {11'd0, ps[0]}, 16'h0000);

    we = 1'b1; waddr = 4'd5; wdata = 16'h1234;
    tick;
    waddr = 4'd10; wdata = 16'hBEEF;
    tick;
    we = 1'b0; wdata = 16'hFFFF; raddr_src = 4'd5; raddr_dest = 4'd10;
    #1;
    check("wr_r5", rs[0], 16'h1234);
    check("wr_r10", rd[0], 16'hBEEF);
    check("wr_r5_nobyp", rs[1], 16'h1234);
    for (int i = 0; i < 16; i++) begin
      raddr_src = 4'(i); raddr_dest = 4'(15 - i);
      tick;
    end
    raddr_src = 4'd4;
    #1;
    check("other_r4", rs[0], 16'h0000);

    we = 1'b1; waddr = 4'd7; wdata = 16'hA5A5; raddr_src = 4'd7; raddr_dest = 4'd7;
    #1;
    check("byp_src", rs[0], 16'hA5A5);
    check("byp_dest", rd[0], 16'hA5A5);
    check("nobyp_old", rs[1], 16'h0000);
    tick;
    we = 1'b0;
    #1;
    check("nobyp_new", rs[1], 16'hA5A5);

    flags_in = 5'b11111; flag_we = 5'b01010;
    tick;
    flags_in = 5'b00000; flag_we = 5'b00000;
    #1;
    check("mask_psr", {11'd0, ps[0]}, {11'd0, 5'b01010});
    tick;
    check("mask_hold", {11'd0, ps[0]}, {11'd0, 5'b01010});

    for (int v = 0; v < 4; v++) begin
      psr_load = 1'b1; psr_wdata = fv_start[v];
      tick;
      psr_load = 1'b0; flags_in = fv_flags[v]; flag_we = fv_mask[v];
      tick;
      flag_we = 5'b00000; flags_in = 5'b11111;
      #1;
      check($sformatf("mask_vec%0d", v), {11'd0, ps[0]}, {11'd0, fv_exp[v]});
    end

    psr_load = 1'b1; psr_wdata = 5'b10001; flag_we = 5'b11111; flags_in = 5'b01110;
    tick;
    psr_load = 1'b0; flag_we = 5'b00000;
    #1;
    check("prio_psr", {11'd0, ps[0]}, {11'd0, 5'b10001});
    reset = 1'b1; psr_load = 1'b1; psr_wdata = 5'b11111; we = 1'b1; waddr = 4'd5; wdata = 16'h7777;
    tick;
    reset = 1'b0; psr_load = 1'b0; we = 1'b0; raddr_src = 4'd5;
    #1;
    check("rst_prio_psr", {11'd0, ps[0]}, 16'h0000);
    check("rst_drop_wr", rs[0], 16'h0000);

    we = 1'b1; waddr = 4'd2; wdata = 16'h0042;
    tick;
    we = 1'b0; raddr_src = 4'd2; raddr_dest = 4'd2;
    #1;
    check("same_src", rs[0], 16'h0042);
    check("same_dest", rd[0], 16'h0042);

    we = 1'b1; waddr = 4'd14; wdata = 16'h5555; raddr_src = 4'd14; raddr_dest = 4'd11;
    #1;
    check("oor_byp_small", rs[2], 16'h0000);
    tick;
    we = 1'b0;
    #1;
    check("oor_small", rs[2], 16'h0000);
    check("oor_big", rs[0], 16'h5555);
    check("r11_small", rd[2], 16'h0000);
    for (int i = 0; i < 16; i++) begin
      raddr_src = 4'(i); raddr_dest = 4'(i);
      tick;
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
